// File: rtl/method_call_driver.sv
// method_call_driver: invokes one req/busy/return method, checks the returned value
// against EXPECTED, and reports pass/fail/timeout plus the call latency.
module method_call_driver #(
    parameter int RET_WIDTH = 32,
    parameter logic [RET_WIDTH-1:0] EXPECTED = 1,
    parameter int STARTUP_CYCLES = 100,
    parameter int TIMEOUT = 10000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 method_req,
    input  logic                 method_busy,
    input  logic [RET_WIDTH-1:0] method_return,
    output logic                 running,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timed_out,
    output logic [RET_WIDTH-1:0] result,
    output logic [31:0]          latency
);
    typedef enum logic [2:0] {IDLE, STARTUP, REQ, WAIT, DONE} state_t;
    localparam logic [31:0] TO = 32'(TIMEOUT);
    localparam logic [31:0] SU_LAST = 32'(STARTUP_CYCLES - 1);
    state_t state;
    logic [31:0] su_cnt, lat_cnt, lat_nx;
    logic expired, ok;
    assign lat_nx = (lat_cnt == 32'hFFFF_FFFF) ? lat_cnt : lat_cnt + 32'd1;
    assign expired = lat_nx >= TO;
    assign ok = method_return == EXPECTED;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            method_req <= 1'b0;
            running <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            timed_out <= 1'b0;
            result <= '0;
            latency <= '0;
            su_cnt <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= (STARTUP_CYCLES == 0) ? REQ : STARTUP;
                    method_req <= (STARTUP_CYCLES == 0);
                    running <= 1'b1;
                    done <= 1'b0;
                    pass <= 1'b0;
                    fail <= 1'b0;
                    timed_out <= 1'b0;
                    result <= '0;
                    latency <= '0;
                    su_cnt <= '0;
                    lat_cnt <= '0;
                end
                STARTUP: if (su_cnt == SU_LAST) begin
                    state <= REQ;
                    method_req <= 1'b1;
                end else begin
                    su_cnt <= su_cnt + 32'd1;
                end
                REQ: begin
                    lat_cnt <= lat_nx;
                    if (expired) begin
                        state <= DONE;
                        method_req <= 1'b0;
                        running <= 1'b0;
                        done <= 1'b1;
                        fail <= 1'b1;
                        timed_out <= 1'b1;
                        latency <= lat_nx;
                    end else if (method_busy) begin
                        state <= WAIT;
                        method_req <= 1'b0;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_nx;
                    // completion takes priority over a timeout on the same edge
                    if (!method_busy || expired) begin
                        state <= DONE;
                        running <= 1'b0;
                        done <= 1'b1;
                        latency <= lat_nx;
                        pass <= !method_busy && ok;
                        fail <= method_busy || !ok;
                        timed_out <= method_busy;
                        result <= method_busy ? '0 : method_return;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/method_call_driver.md
# method_call_driver

Synthesizable driver that invokes one Synthesijer-generated method over its req/busy/return handshake, waits for completion, captures the return value and checks it against an expected value, with a cycle timeout. It sits directly upstream of a generated design such as Test002 and replaces free-running testbench logic so that self-checking runs work both in simulation and on a board. The pass/fail/timeout status and the measured call latency go to a status register or LEDs.

## Interface
Parameters:
- RET_WIDTH, 32, width of the method return value
- EXPECTED, 1, return value required for pass (truncated to RET_WIDTH)
- STARTUP_CYCLES, 100, idle cycles between start and req assertion (0 allowed)
- TIMEOUT, 10000, maximum cycles from req assertion to completion; must be ≥ 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  single-cycle pulse; accepted only in IDLE or DONE
- method_req  out  1  to the method's _req input
- method_busy  in  1  from the method's _busy output
- method_return  in  RET_WIDTH  from the method's _return output
- running  out  1  high from start acceptance until DONE
- done  out  1  high in DONE; held until next start or reset
- pass  out  1  valid with done: return == EXPECTED and no timeout
- fail  out  1  valid with done: return != EXPECTED or timeout
- timed_out  out  1  valid with done: TIMEOUT expired
- result  out  RET_WIDTH  captured method_return
- latency  out  32  cycles from first req cycle to the busy-low cycle, inclusive of the req cycle

## Operation
- States: IDLE, STARTUP, REQ, WAIT, DONE.
- IDLE: all outputs 0. start=1 -> STARTUP (or REQ directly when STARTUP_CYCLES=0); clear counters.
- STARTUP: count STARTUP_CYCLES cycles, then -> REQ.
- REQ: method_req=1. Hold until method_busy=1 is sampled, then -> WAIT with method_req=0 in the next cycle. A method that never raises busy ends in timeout.
- WAIT: method_req=0. When method_busy=0 is sampled, capture method_return into result, set pass/fail, -> DONE.
- DONE: done=1; pass, fail, timed_out, result and latency are frozen. start=1 -> restart exactly as from IDLE; flags clear the cycle after acceptance.
- Timeout: the latency counter runs in REQ and WAIT. When it reaches TIMEOUT without completion: timed_out=1, fail=1, pass=0, result=0, method_req=0, -> DONE.
- Flags: pass and fail are mutually exclusive; exactly one is 1 in DONE.
- Arithmetic: the result comparison is an unsigned RET_WIDTH-bit equality. latency saturates at 32'hFFFFFFFF and cannot exceed TIMEOUT.
- start while in STARTUP, REQ or WAIT is ignored.

## Timing
- Reset (asynchronous): state=IDLE; method_req, running, done, pass, fail and timed_out are 0; result and latency are 0.
- start sampled high at edge N -> running=1 after edge N; with STARTUP_CYCLES=S, method_req rises after edge N+S (after edge N when S=0 plus state change, i.e. first REQ cycle follows edge N).
- Busy sampled high at edge M -> method_req=0 after edge M.
- Busy sampled low in WAIT at edge K -> done/pass/fail/result valid after edge K, and running=0.
- Busy already high on the first REQ cycle is accepted immediately, giving exactly one req cycle.
- Reset mid-call drops method_req asynchronously. The driver does not reset the downstream method.
- Completion and timeout on the same edge: completion wins; the result is checked normally.

## Test plan
- Nominal: STARTUP_CYCLES=100, EXPECTED=1; the model raises busy 1 cycle after req, holds it 20 cycles, returns 1 -> done=1, pass=1, fail=0, result=1, latency=22.
- Wrong value: same stimulus but the return is 0 -> done=1, fail=1, pass=0, timed_out=0, result=0.
- Timeout: TIMEOUT=50; busy never falls -> done=1, timed_out=1, fail=1 exactly 50 cycles after the first req cycle; method_req=0.
- No-busy method: busy never rises -> method_req held high for 50 cycles, then timeout as above.
- Restart and ignore: start pulsed during WAIT -> no effect. start in DONE -> flags clear, a second call runs, and latency is re-measured.
- Reset mid-WAIT: assert reset 5 cycles into WAIT -> all outputs 0 immediately, IDLE. After start, a fresh call passes.
